da_slice_tx: RTL

Bit-slice transmitter for the distributed-arithmetic (DA) matrix-vector datapath. It accepts one 3x3 signed 8-bit matrix per frame, stores it, and emits one 3-bit address slice per row per beat over a valid/ready stream. Slices go out MSB-first by default, with the sign (MSB) beat flagged so the downstream DA accumulator can subtract it. It sits between the operand source and the DA LUT/accumulator, and replaces the combinational bit-indexing previously done inside the accumulator.

---
 rtl/da_pkg.sv | 19 +
 rtl/da_slice_tx_if.sv | 40 ++++
 rtl/da_slice_tx_row_slicer.sv | 39 +++
 rtl/da_slice_tx.sv | 114 +++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic slice datapath.
//   state_t : transmitter frame state (IDLE, SEND, DONE)
//   DA_W    : default operand width (also the beat count per frame)
//   DA_ROWS : matrix rows / bits per slice
//   slice_t : one row's address slice, {op2[i], op1[i], op0[i]}
package da_pkg;

    localparam int unsigned DA_W    = 8;
    localparam int unsigned DA_ROWS = 3;

    typedef logic [DA_ROWS-1:0] slice_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/da_slice_tx_if.sv
// Load/stream bundle of the DA bit-slice transmitter.
//   a..j     : 3x3 matrix operands; rows {a,b,c}, {d,e,f}, {g,h,j}
//   ld_valid : operands valid        ld_ready : transmitter can capture
//   abort    : cancel current frame
//   s_valid  : slice beat valid      s_ready  : consumer accepts beat
//   sl0..sl2 : row slices            sl_idx   : bit index of the beat
//   sl_sign  : beat is bit W-1       sl_last  : final beat of the frame
//   done     : one-cycle pulse after the last beat is accepted
// Modports: master = operand source / slice consumer, slave = transmitter.
interface da_slice_tx_if
    import da_pkg::*;
#(
    parameter int unsigned W = DA_W
) ();

    localparam int unsigned IW = $clog2(W);

    logic [W-1:0]  a, b, c, d, e, f, g, h, j;
    logic          ld_valid;
    logic          ld_ready;
    logic          abort;
    logic          s_valid;
    logic          s_ready;
    slice_t        sl0, sl1, sl2;
    logic [IW-1:0] sl_idx;
    logic          sl_sign;
    logic          sl_last;
    logic          done;

    modport master (
        output a, b, c, d, e, f, g, h, j, ld_valid, abort, s_ready,
        input  ld_ready, s_valid, sl0, sl1, sl2, sl_idx, sl_sign, sl_last, done
    );

    modport slave (
        input  a, b, c, d, e, f, g, h, j, ld_valid, abort, s_ready,
        output ld_ready, s_valid, sl0, sl1, sl2, sl_idx, sl_sign, sl_last, done
    );

endinterface

// File: rtl/da_slice_tx_row_slicer.sv
// da_row_slicer: holds one matrix row (three W-bit operands) and presents
// the 3-bit slice {op2[idx], op1[idx], op0[idx]} for the requested bit.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   ld_en_i           : capture op0_i..op2_i on this edge
//   op0_i..op2_i      : row operands (op0 is the slice LSB)
//   idx_i             : bit index to present
//   slice_o           : combinational slice from the stored operands
module da_row_slicer
    import da_pkg::*;
#(
    parameter int unsigned W = DA_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ld_en_i,
    input  logic [W-1:0]         op0_i,
    input  logic [W-1:0]         op1_i,
    input  logic [W-1:0]         op2_i,
    input  logic [$clog2(W)-1:0] idx_i,
    output slice_t               slice_o
);

    logic [W-1:0] op0_q, op1_q, op2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op0_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else if (ld_en_i) begin
            op0_q <= op0_i;
            op1_q <= op1_i;
            op2_q <= op2_i;
        end
    end

    assign slice_o = {op2_q[idx_i], op1_q[idx_i], op0_q[idx_i]};

endmodule

// File: rtl/da_slice_tx.sv
// da_slice_tx: bit-slice transmitter for the DA matrix-vector datapath.
// Captures a 3x3 operand matrix in IDLE, then streams W beats of three
// row slices over a valid/ready handshake, then pulses done for one cycle.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : da_slice_tx_if.slave (operands, load handshake, abort,
//           slice stream, done)
// Build option: DA_SLICE_TX_LSB_FIRST_EN sends bit 0 first (counter counts
// up); by default bit W-1 goes first. The sign beat (bit W-1) is flagged in
// either order; latencies are the same in both builds.
module da_slice_tx
    import da_pkg::*;
#(
    parameter int unsigned W = DA_W
) (
    input logic          clk,
    input logic          reset,
    da_slice_tx_if.slave bus
);

    localparam int unsigned IW = $clog2(W);

`ifdef DA_SLICE_TX_LSB_FIRST_EN
    localparam bit            LSB_FIRST = 1'b1;
    localparam logic [IW-1:0] CNT_START = '0;
    localparam logic [IW-1:0] CNT_LAST  = IW'(W-1);
`else
    localparam bit            LSB_FIRST = 1'b0;
    localparam logic [IW-1:0] CNT_START = IW'(W-1);
    localparam logic [IW-1:0] CNT_LAST  = '0;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          load_en;
    logic          send;
    slice_t        row0_sl, row1_sl, row2_sl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // abort wins over a beat accepted in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_valid) begin
                    load_en = 1'b1;
                    cnt_d   = CNT_START;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.s_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else if (LSB_FIRST) begin
                        cnt_d = cnt_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q - IW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    da_row_slicer #(.W(W)) u_row0 (
        .clk_i(clk), .rst_i(reset), .ld_en_i(load_en),
        .op0_i(bus.a), .op1_i(bus.b), .op2_i(bus.c),
        .idx_i(cnt_q), .slice_o(row0_sl)
    );

    da_row_slicer #(.W(W)) u_row1 (
        .clk_i(clk), .rst_i(reset), .ld_en_i(load_en),
        .op0_i(bus.d), .op1_i(bus.e), .op2_i(bus.f),
        .idx_i(cnt_q), .slice_o(row1_sl)
    );

    da_row_slicer #(.W(W)) u_row2 (
        .clk_i(clk), .rst_i(reset), .ld_en_i(load_en),
        .op0_i(bus.g), .op1_i(bus.h), .op2_i(bus.j),
        .idx_i(cnt_q), .slice_o(row2_sl)
    );

    assign send = (state_q == SEND);

    // Stream outputs are forced to zero outside SEND so reset and idle
    // present a quiet bus; ld_ready is held low for the whole reset pulse.
    always_comb begin
        bus.ld_ready = (state_q == IDLE) && !reset;
        bus.s_valid  = send;
        bus.done     = (state_q == DONE);
        bus.sl0      = send ? row0_sl : '0;
        bus.sl1      = send ? row1_sl : '0;
        bus.sl2      = send ? row2_sl : '0;
        bus.sl_idx   = send ? cnt_q : '0;
        bus.sl_sign  = send && (cnt_q == IW'(W-1));
        bus.sl_last  = send && (cnt_q == CNT_LAST);
    end

endmodule
